// File: rtl/mensage_streamer.sv
// Streams one ROM-resident message per request through a valid/ready port.
// The external ROM is addressed by {msg_id, char_idx} and answers combinationally.
module mensage_streamer #(
  parameter int N_MSG   = 3,
  parameter int CHAR_W  = 4,
  parameter int LEN_W   = 4,
  parameter int MAX_LEN = 15,
  localparam int ID_W   = (N_MSG > 1) ? $clog2(N_MSG) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_MSG-1:0]  req,
  input  logic              repeat_mode,
  input  logic              abort,
  output logic [ID_W-1:0]   msg_id,
  output logic [LEN_W-1:0]  char_idx,
  input  logic [CHAR_W-1:0] rom_char,
  input  logic [LEN_W-1:0]  rom_len,
  output logic [CHAR_W-1:0] out_char,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  // state  | meaning
  // IDLE   | waiting for a request; lowest set req bit wins
  // LOAD   | latch clamped length from ROM, rewind index
  // SEND   | offer characters until the last one is taken
  // FINISH | one-cycle done pulse, then back to IDLE
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SEND, S_FINISH} state_t;

  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);

  state_t            state_q, state_d;
  logic [ID_W-1:0]   msg_id_q, msg_id_d;
  logic [LEN_W-1:0]  idx_q, idx_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [ID_W-1:0]   req_first;
  logic [LEN_W-1:0]  len_clamp;
  logic              is_last;

  always_comb begin
    req_first = '0;
    for (int k = N_MSG - 1; k >= 0; k--) begin
      if (req[k]) req_first = ID_W'(k);
    end
  end

  assign len_clamp = (rom_len > LEN_MAX) ? LEN_MAX : rom_len;
  assign is_last   = (idx_q == len_q - LEN_W'(1));

  always_comb begin
    state_d  = state_q;
    msg_id_d = msg_id_q;
    idx_d    = idx_q;
    len_d    = len_q;
    case (state_q)
      S_IDLE: begin
        if (!abort && (req != '0)) begin
          msg_id_d = req_first;
          state_d  = S_LOAD;
        end
      end
      S_LOAD: begin
        if (abort) begin
          state_d = S_IDLE;
        end else begin
          len_d   = len_clamp;
          idx_d   = '0;
          state_d = (len_clamp == '0) ? S_FINISH : S_SEND;
        end
      end
      S_SEND: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (out_ready) begin
          if (!is_last) begin
            idx_d = idx_q + LEN_W'(1);
          end else if (repeat_mode && req[msg_id_q]) begin
            idx_d = '0;
          end else begin
            state_d = S_FINISH;
          end
        end
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      msg_id_q <= '0;
      idx_q    <= '0;
      len_q    <= '0;
    end else begin
      state_q  <= state_d;
      msg_id_q <= msg_id_d;
      idx_q    <= idx_d;
      len_q    <= len_d;
    end
  end

  // An abort landing on FINISH suppresses the completion pulse.
  assign msg_id    = msg_id_q;
  assign char_idx  = idx_q;
  assign out_char  = rom_char;
  assign out_valid = (state_q == S_SEND);
  assign out_last  = (state_q == S_SEND) && is_last;
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_FINISH) && !abort;

endmodule

// File: tb/tb_mensage_streamer.sv
// Directed bench for mensage_streamer with a small behavioural message ROM.
module tb_mensage_streamer;

  localparam int N_MSG  = 3;
  localparam int CHAR_W = 4;
  localparam int LEN_W  = 5;
  localparam int ID_W   = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [N_MSG-1:0]  req = '0;
  logic              repeat_mode = 1'b0;
  logic              abort = 1'b0;
  logic [ID_W-1:0]   msg_id;
  logic [LEN_W-1:0]  char_idx;
  logic [CHAR_W-1:0] rom_char;
  logic [LEN_W-1:0]  rom_len;
  logic [CHAR_W-1:0] out_char;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic              out_last;
  logic              busy;
  logic              done;

  logic [LEN_W-1:0]  len_tab [4];
  int total = 0;
  int bad   = 0;

  mensage_streamer #(
    .N_MSG(N_MSG), .CHAR_W(CHAR_W), .LEN_W(LEN_W), .MAX_LEN(15)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .repeat_mode(repeat_mode),
    .abort(abort), .msg_id(msg_id), .char_idx(char_idx),
    .rom_char(rom_char), .rom_len(rom_len), .out_char(out_char),
    .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  always_comb begin
    rom_char = CHAR_W'((int'(msg_id) * 3 + int'(char_idx)) % 16);
    rom_len  = len_tab[msg_id];
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called in an IDLE cycle; returns at the start of the first SEND (or FINISH) cycle.
  task automatic start(input logic [N_MSG-1:0] r, input int m, input bit hold);
    req = r;
    #1;
    check("idle_busy", busy, 0);
    cyc();
    if (!hold) req = '0;
    #1;
    check("load_busy", busy, 1);
    check("load_valid", out_valid, 0);
    check("load_msg_id", msg_id, m);
    cyc();
  endtask

  // n transfers of message m (length len) starting at index first.
  task automatic stream(input int m, input int len, input int first, input int n, input bit stall);
    for (int i = 0; i < n; i++) begin
      int ix;
      ix = (first + i) % len;
      if (stall) begin
        out_ready = 1'b0;
        #1;
        check("stall_valid", out_valid, 1);
        check("stall_char", out_char, (m * 3 + ix) % 16);
        check("stall_idx", char_idx, ix);
        cyc();
      end
      out_ready = 1'b1;
      #1;
      check("xfer_valid", out_valid, 1);
      check("xfer_char", out_char, (m * 3 + ix) % 16);
      check("xfer_idx", char_idx, ix);
      check("xfer_last", out_last, (ix == len - 1) ? 1 : 0);
      check("xfer_msg_id", msg_id, m);
      check("xfer_no_done", done, 0);
      cyc();
    end
  endtask

  task automatic fin();
    #1;
    check("fin_done", done, 1);
    check("fin_valid", out_valid, 0);
    check("fin_busy", busy, 1);
    cyc();
    check("after_done", done, 0);
    check("after_busy", busy, 0);
  endtask

  initial begin
    len_tab[0] = 5'd6;
    len_tab[1] = 5'd12;
    len_tab[2] = 5'd9;
    len_tab[3] = 5'd0;
    #2;
    check("rst_busy", busy, 0);
    check("rst_valid", out_valid, 0);
    check("rst_done", done, 0);
    check("rst_msg_id", msg_id, 0);
    check("rst_idx", char_idx, 0);
    cyc();
    rst_n = 1'b1;
    cyc();

    // message 0, always ready
    start(3'b001, 0, 0);
    stream(0, 6, 0, 6, 0);
    fin();

    // lowest set bit wins, request held, restarts after one IDLE cycle
    start(3'b110, 1, 1);
    stream(1, 12, 0, 12, 0);
    fin();
    cyc();
    check("restart_busy", busy, 1);
    check("restart_msg_id", msg_id, 1);
    abort = 1'b1;
    req = '0;
    #1;
    check("abort_load_done", done, 0);
    cyc();
    abort = 1'b0;
    check("abort_load_busy", busy, 0);

    // stalls every other cycle
    start(3'b100, 2, 0);
    stream(2, 9, 0, 9, 1);
    fin();

    // repeat mode with request held, then released
    repeat_mode = 1'b1;
    start(3'b100, 2, 1);
    stream(2, 9, 0, 20, 0);
    req = '0;
    stream(2, 9, 2, 7, 0);
    fin();
    repeat_mode = 1'b0;

    // zero length, then clamped length
    len_tab[0] = 5'd0;
    start(3'b001, 0, 0);
    fin();
    len_tab[0] = 5'd31;
    start(3'b001, 0, 0);
    stream(0, 15, 0, 15, 0);
    fin();
    len_tab[0] = 5'd6;

    // abort at the third character
    start(3'b001, 0, 0);
    stream(0, 6, 0, 2, 0);
    abort = 1'b1;
    out_ready = 1'b0;
    #1;
    check("abort3_valid", out_valid, 1);
    check("abort3_idx", char_idx, 2);
    cyc();
    check("abort3_busy", busy, 0);
    check("abort3_done", done, 0);
    abort = 1'b0;
    out_ready = 1'b1;
    start(3'b010, 1, 0);
    stream(1, 12, 0, 12, 0);
    fin();

    // abort together with the final transfer
    start(3'b001, 0, 0);
    stream(0, 6, 0, 5, 0);
    abort = 1'b1;
    #1;
    check("abort_last_flag", out_last, 1);
    cyc();
    check("abort_last_busy", busy, 0);
    check("abort_last_done", done, 0);
    abort = 1'b0;

    // abort coinciding with FINISH
    start(3'b001, 0, 0);
    stream(0, 6, 0, 6, 0);
    abort = 1'b1;
    #1;
    check("abort_fin_done", done, 0);
    cyc();
    check("abort_fin_busy", busy, 0);

    // abort in IDLE masks a simultaneous request
    req = 3'b001;
    cyc();
    check("abort_idle_busy", busy, 0);
    abort = 1'b0;
    req = '0;
    cyc();

    // reset at the third character
    start(3'b100, 2, 0);
    stream(2, 9, 0, 2, 0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_idx", char_idx, 0);
    check("mid_rst_msg_id", msg_id, 0);
    check("mid_rst_done", done, 0);
    cyc();
    rst_n = 1'b1;
    start(3'b001, 0, 0);
    stream(0, 6, 0, 6, 0);
    fin();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
